// File: rtl/ei_axi4_slave_wr_mem_pkg.sv
// Shared encodings for the AXI4 write-path slave: burst types, response
// codes and the write FSM state.
package ei_axi4_rtl_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_e;

endpackage

// File: rtl/ei_axi4_slave_wr_mem_if.sv
// AXI4 write channels (AW/W/B) bundled for the write-path slave.
interface ei_axi4_slave_wr_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/ei_axi4_slave_wr_mem_burst_addr_gen.sv
// Combinational next-beat address and burst legality for AXI4 bursts.
module ei_axi4_burst_addr_gen
  import ei_axi4_rtl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);
  localparam int SIZE_MAX = $clog2(DATA_W/8);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_bytes;
  logic              wrap_len_ok;

  // Address step per burst type plus configuration legality check
  always_comb begin
    step        = ADDR_W'(1) << size;
    wrap_bytes  = (ADDR_W'(len) + ADDR_W'(1)) << size;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr   = addr;
    case (burst)
      INCR:    next_addr = (addr & ~(step - ADDR_W'(1))) + step;
      WRAP:    next_addr = (addr & ~(wrap_bytes - ADDR_W'(1))) |
                           ((addr + step) & (wrap_bytes - ADDR_W'(1)));
      default: next_addr = addr;
    endcase
    illegal = (size > 3'(SIZE_MAX)) || (burst == 2'b11) ||
              ((burst == WRAP) && !wrap_len_ok);
  end
endmodule

// File: rtl/ei_axi4_slave_wr_mem.sv
// AXI4 write-path slave with a byte-addressable memory and a combinational
// debug read port. One burst at a time: IDLE -> DATA -> RESP.
module ei_axi4_slave_wr_mem
  import ei_axi4_rtl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  ei_axi4_slave_wr_mem_if.slave bus,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]    dbg_rdata
);
  localparam int NB    = DATA_W/8;
  localparam int LSB   = $clog2(NB);
  localparam int WORDS = MEM_BYTES/NB;
  localparam int WA    = (WORDS > 1) ? $clog2(WORDS) : 1;

  wr_state_e         state, state_nxt;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   id_q;
  resp_e             bresp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, beat_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;

  logic              aw_hs, w_hs, b_hs, last_beat, in_range, beat_err, illegal;
  logic [ADDR_W-1:0] next_addr;

  logic [DATA_W-1:0] mem [WORDS];

  ei_axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .illegal   (illegal)
  );

  assign aw_hs     = bus.awvalid && awready_q;
  assign w_hs      = bus.wvalid && wready_q;
  assign b_hs      = bvalid_q && bus.bready;
  assign last_beat = (beat_q == len_q);
  assign in_range  = (addr_q < ADDR_W'(MEM_BYTES));
  // A beat is in error if it is dropped for range or its wlast disagrees with the count
  assign beat_err  = !in_range || (bus.wlast != last_beat);

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = id_q;
  assign bus.bresp   = bresp_q;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = DATA;
      DATA:    if (w_hs && last_beat) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they stay low in reset
  // and awready rises on the first edge after reset releases
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= (state_nxt == IDLE);
      wready_q  <= (state_nxt == DATA);
      bvalid_q  <= (state_nxt == RESP);
    end
  end

  // Burst context capture, beat tracking and sticky error accumulation
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      id_q    <= '0;
      bresp_q <= OKAY;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else if (aw_hs) begin
      id_q    <= bus.awid;
      addr_q  <= bus.awaddr;
      len_q   <= bus.awlen;
      size_q  <= bus.awsize;
      burst_q <= bus.awburst;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else if (w_hs) begin
      addr_q <= next_addr;
      beat_q <= beat_q + 8'd1;
      err_q  <= err_q || beat_err;
      if (last_beat) bresp_q <= (err_q || beat_err || illegal) ? SLVERR : OKAY;
    end
  end

  // Byte-enabled memory write; contents survive reset
  always_ff @(posedge aclk) begin
    if (w_hs && in_range && !illegal) begin
      for (int b = 0; b < NB; b++)
        if (bus.wstrb[b]) mem[WA'(addr_q >> LSB)][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
  end

  // Debug read of the word at dbg_addr, zero when outside the memory
  always_comb begin
    dbg_rdata = '0;
    if (dbg_addr < ADDR_W'(MEM_BYTES)) dbg_rdata = mem[WA'(dbg_addr >> LSB)];
  end
endmodule
